// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the raster timing generator.
// The optional border feature is enabled with VIDEO_TIMING_BORDER_EN.
package video_timing_pkg;

  localparam int CNT_W     = 12;
  localparam int MAX_TOTAL = 4096;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic frame_start;
  } timing_flags_t;

  function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/video_timing_axis.sv
// Single raster axis: position counter that wraps at TOTAL-1, plus active/sync
// decode of the value the counter takes on the next edge.
module video_timing_axis
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = 320,
  parameter int FP     = 8,
  parameter int SYNC   = 32,
  parameter int BP     = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             step,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             wrap,
  output logic             act_nxt,
  output logic             sync_nxt
);

  localparam int CW1   = CNT_W + 1;
  localparam int TOTAL = calc_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CW1-1:0]   ACT_END  = CW1'(ACTIVE);
  localparam logic [CW1-1:0]   SYNC_BEG = CW1'(ACTIVE + FP);
  localparam logic [CW1-1:0]   SYNC_END = CW1'(ACTIVE + FP + SYNC);

  logic at_last;

  assign at_last = (cnt == LAST);

  // A clear parks the counter on the last position so the next step lands on 0.
  always_comb begin
    wrap    = 1'b0;
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = LAST;
    end else if (step) begin
      wrap    = at_last;
      cnt_nxt = at_last ? '0 : cnt + 1'b1;
    end
  end

  assign act_nxt  = ({1'b0, cnt_nxt} < ACT_END);
  assign sync_nxt = ({1'b0, cnt_nxt} >= SYNC_BEG) && ({1'b0, cnt_nxt} < SYNC_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= LAST;
    else        cnt <= cnt_nxt;
  end

endmodule

// File: rtl/video_timing_gen.sv
// Programmable raster timing generator with pixel divider and one-pixel fetch lookahead.
// Define VIDEO_TIMING_BORDER_EN to add the BORDER input and IN_BORDER output.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 15,
  parameter int CE_DIV   = 4
) (
  input  logic             CLK_VIDEO,
  input  logic             RESET_N,
  input  logic             ENABLE,
`ifdef VIDEO_TIMING_BORDER_EN
  input  logic [3:0]       BORDER,
  output logic             IN_BORDER,
`endif
  output logic             CE_PIXEL,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_DE,
  output logic             FRAME_START,
  output logic [CNT_W-1:0] HCOUNT,
  output logic [CNT_W-1:0] VCOUNT,
  output logic             FETCH_VALID,
  output logic [CNT_W-1:0] PIX_X,
  output logic [CNT_W-1:0] PIX_Y
);

  localparam int CW1     = CNT_W + 1;
  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CW1-1:0]   H_ACT_E  = CW1'(H_ACTIVE);
  localparam logic [CW1-1:0]   V_ACT_E  = CW1'(V_ACTIVE);
  localparam logic [3:0]       DIV_LAST = 4'(CE_DIV - 1);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_total_chk
    $error("video_timing_gen: H_TOTAL/V_TOTAL exceed counter range");
  end
  if (CE_DIV < 1 || CE_DIV > 16) begin : g_div_chk
    $error("video_timing_gen: CE_DIV must be 1..16");
  end

  logic [3:0]       div;
  logic             tick;
  logic             ce_q;
  logic [CNT_W-1:0] h_cnt, h_nxt, v_cnt, v_nxt;
  logic             h_wrap, v_wrap, h_act, v_act, h_sync, v_sync;
  logic             de_nxt;
  timing_flags_t    flags_nxt, flags_q;
  logic [CNT_W-1:0] px_nxt, py_nxt, px_q, py_q;
  logic             fv_nxt, fv_q;
  logic             h_succ_wrap;

  assign tick = (div == DIV_LAST);

  video_timing_axis #(
    .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP)
  ) u_h_axis (
    .clk      (CLK_VIDEO),
    .rst_n    (RESET_N),
    .clr      (!ENABLE),
    .step     (ENABLE && tick),
    .cnt      (h_cnt),
    .cnt_nxt  (h_nxt),
    .wrap     (h_wrap),
    .act_nxt  (h_act),
    .sync_nxt (h_sync)
  );

  video_timing_axis #(
    .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP)
  ) u_v_axis (
    .clk      (CLK_VIDEO),
    .rst_n    (RESET_N),
    .clr      (!ENABLE),
    .step     (h_wrap),
    .cnt      (v_cnt),
    .cnt_nxt  (v_nxt),
    .wrap     (v_wrap),
    .act_nxt  (v_act),
    .sync_nxt (v_sync)
  );

`ifdef VIDEO_TIMING_BORDER_EN
  localparam int B_LIM = min_int(min_int(min_int(H_FP, H_BP), min_int(V_FP, V_BP)), 15);
  localparam logic [CW1-1:0] H_TOT_E = CW1'(H_TOTAL);
  localparam logic [CW1-1:0] V_TOT_E = CW1'(V_TOTAL);

  logic [3:0] border_q, border_new, border_eff;
  logic       h_win, v_win, in_border_q;

  // The frame-start pixel already uses the freshly sampled width.
  assign border_new = (BORDER > 4'(B_LIM)) ? 4'(B_LIM) : BORDER;
  assign border_eff = v_wrap ? border_new : border_q;
  assign h_win  = ({1'b0, h_nxt} < H_ACT_E + CW1'(border_eff)) ||
                  ({1'b0, h_nxt} + CW1'(border_eff) >= H_TOT_E);
  assign v_win  = ({1'b0, v_nxt} < V_ACT_E + CW1'(border_eff)) ||
                  ({1'b0, v_nxt} + CW1'(border_eff) >= V_TOT_E);
  assign de_nxt = h_win && v_win;

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      border_q    <= '0;
      in_border_q <= 1'b0;
    end else if (!ENABLE) begin
      border_q    <= '0;
      in_border_q <= 1'b0;
    end else if (tick) begin
      if (v_wrap) border_q <= border_new;
      in_border_q <= de_nxt && !(h_act && v_act);
    end
  end

  assign IN_BORDER = in_border_q;
`else
  assign de_nxt = h_act && v_act;
`endif

  always_comb begin
    flags_nxt.de          = de_nxt;
    flags_nxt.hs          = h_sync;
    flags_nxt.vs          = v_sync;
    flags_nxt.frame_start = v_wrap;
  end

  // Fetch address is the raster successor of the position being loaded.
  assign h_succ_wrap = (h_nxt == H_LAST);
  assign px_nxt = h_succ_wrap ? '0 : h_nxt + 1'b1;
  assign py_nxt = h_succ_wrap ? ((v_nxt == V_LAST) ? '0 : v_nxt + 1'b1) : v_nxt;
  assign fv_nxt = ({1'b0, px_nxt} < H_ACT_E) && ({1'b0, py_nxt} < V_ACT_E);

  always_ff @(posedge CLK_VIDEO or negedge RESET_N) begin
    if (!RESET_N) begin
      div     <= '0;
      ce_q    <= 1'b0;
      flags_q <= '0;
      px_q    <= '0;
      py_q    <= '0;
      fv_q    <= 1'b1;
    end else if (!ENABLE) begin
      div     <= '0;
      ce_q    <= 1'b0;
      flags_q <= '0;
      px_q    <= '0;
      py_q    <= '0;
      fv_q    <= 1'b1;
    end else begin
      div  <= tick ? 4'd0 : div + 4'd1;
      ce_q <= tick;
      if (tick) begin
        flags_q <= flags_nxt;
        px_q    <= px_nxt;
        py_q    <= py_nxt;
        fv_q    <= fv_nxt;
      end
    end
  end

  assign CE_PIXEL    = ce_q;
  assign VGA_DE      = flags_q.de;
  assign VGA_HS      = flags_q.hs;
  assign VGA_VS      = flags_q.vs;
  assign FRAME_START = flags_q.frame_start;
  assign HCOUNT      = h_cnt;
  assign VCOUNT      = v_cnt;
  assign FETCH_VALID = fv_q;
  assign PIX_X       = px_q;
  assign PIX_Y       = py_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: random ENABLE drops against a raster-index model.
// Also exercises the border widening when VIDEO_TIMING_BORDER_EN is defined.
module tb_video_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int CED = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int BLIM = 1;

  logic        CLK_VIDEO = 1'b0;
  logic        RESET_N   = 1'b1;
  logic        ENABLE    = 1'b0;
  logic [3:0]  BORDER    = 4'd0;
  logic        IN_BORDER;
  logic        CE_PIXEL, VGA_HS, VGA_VS, VGA_DE, FRAME_START, FETCH_VALID;
  logic [11:0] HCOUNT, VCOUNT, PIX_X, PIX_Y;

  video_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .CE_DIV   (CED)
  ) dut (
    .CLK_VIDEO   (CLK_VIDEO),
    .RESET_N     (RESET_N),
    .ENABLE      (ENABLE),
`ifdef VIDEO_TIMING_BORDER_EN
    .BORDER      (BORDER),
    .IN_BORDER   (IN_BORDER),
`endif
    .CE_PIXEL    (CE_PIXEL),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_DE      (VGA_DE),
    .FRAME_START (FRAME_START),
    .HCOUNT      (HCOUNT),
    .VCOUNT      (VCOUNT),
    .FETCH_VALID (FETCH_VALID),
    .PIX_X       (PIX_X),
    .PIX_Y       (PIX_Y)
  );

`ifndef VIDEO_TIMING_BORDER_EN
  assign IN_BORDER = 1'b0;
`endif

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  typedef struct {
    int cyc;
    int ce, h, v, de, hs, vs, fs, fv, px, py, ib;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;
  logic en_at_edge = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, expv, edge_cnt);
    end
  endtask

  function automatic exp_t reset_rec(input int cyc);
    exp_t r;
    r.cyc = cyc; r.ce = 0; r.h = HT - 1; r.v = VT - 1;
    r.de = 0; r.hs = 0; r.vs = 0; r.fs = 0;
    r.fv = 1; r.px = 0; r.py = 0; r.ib = 0;
    return r;
  endfunction

  // k-th pixel tick since the generator started; raster position is k modulo frame size.
  function automatic exp_t pixel_rec(input int cyc, input int k, input int b);
    exp_t r;
    int p, q, act, in_h, in_v;
    p = k % FR;
    q = (p + 1) % FR;
    r.cyc = cyc; r.ce = 1;
    r.h = p % HT; r.v = p / HT;
    act  = (r.h < HA && r.v < VA) ? 1 : 0;
    in_h = (r.h < HA + b || r.h >= HT - b) ? 1 : 0;
    in_v = (r.v < VA + b || r.v >= VT - b) ? 1 : 0;
    r.de = in_h & in_v;
    r.hs = (r.h >= HA + HF && r.h < HA + HF + HS) ? 1 : 0;
    r.vs = (r.v >= VA + VF && r.v < VA + VF + VS) ? 1 : 0;
    r.fs = (p == 0) ? 1 : 0;
    r.px = q % HT; r.py = q / HT;
    r.fv = (r.px < HA && r.py < VA) ? 1 : 0;
    r.ib = r.de & ~act;
    return r;
  endfunction

  always @(posedge CLK_VIDEO) begin
    if (RESET_N) begin
      edge_cnt   <= edge_cnt + 1;
      en_at_edge <= ENABLE;
    end
  end

  // Monitor: every pixel tick or held-in-reset cycle is matched against the queue head.
  always @(negedge CLK_VIDEO) begin
    if (RESET_N && edge_cnt > 0 && (CE_PIXEL || !en_at_edge)) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got CE_PIXEL=%0d with empty queue, expected none (edge %0d)",
                 CE_PIXEL, edge_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("timing_edge", edge_cnt, e.cyc);
        chk("ce_pixel",    CE_PIXEL, e.ce);
        chk("hcount",      HCOUNT, e.h);
        chk("vcount",      VCOUNT, e.v);
        chk("vga_de",      VGA_DE, e.de);
        chk("vga_hs",      VGA_HS, e.hs);
        chk("vga_vs",      VGA_VS, e.vs);
        chk("frame_start", FRAME_START, e.fs);
        chk("fetch_valid", FETCH_VALID, e.fv);
        chk("pix_x",       PIX_X, e.px);
        chk("pix_y",       PIX_Y, e.py);
`ifdef VIDEO_TIMING_BORDER_EN
        chk("in_border",   IN_BORDER, e.ib);
`endif
      end
    end
  end

  initial begin
    int e_cnt, low_left, b_cur, k, n;
    logic en;
    e_cnt = 0; low_left = 0; b_cur = 0;

    ENABLE = 1'b1;
    #2 RESET_N = 1'b0;
    repeat (3) @(negedge CLK_VIDEO);
    chk("rst_ce_pixel",    CE_PIXEL, 0);
    chk("rst_hcount",      HCOUNT, HT - 1);
    chk("rst_vcount",      VCOUNT, VT - 1);
    chk("rst_vga_de",      VGA_DE, 0);
    chk("rst_vga_hs",      VGA_HS, 0);
    chk("rst_vga_vs",      VGA_VS, 0);
    chk("rst_frame_start", FRAME_START, 0);
    chk("rst_fetch_valid", FETCH_VALID, 1);
    chk("rst_pix_x",       PIX_X, 0);
    chk("rst_pix_y",       PIX_Y, 0);
    RESET_N = 1'b1;

    for (int i = 0; i < 4000; i++) begin
      if (i >= 300 && low_left == 0 && $urandom_range(0, 149) == 0)
        low_left = $urandom_range(1, 4);
      en = (low_left == 0);
      if (low_left > 0) low_left--;
      ENABLE = en;
      BORDER = 4'($urandom_range(0, 3));
      n = edge_cnt + 1;
      if (!en) begin
        e_cnt = 0;
        b_cur = 0;
        exp_q.push_back(reset_rec(n));
      end else begin
        e_cnt++;
        if (e_cnt % CED == 0) begin
          k = e_cnt / CED - 1;
`ifdef VIDEO_TIMING_BORDER_EN
          if (k % FR == 0) b_cur = (int'(BORDER) > BLIM) ? BLIM : int'(BORDER);
`endif
          exp_q.push_back(pixel_rec(n, k, b_cur));
        end
      end
      @(negedge CLK_VIDEO);
    end
    #1;
    chk("queue_leftover", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
